// File: rtl/addsub_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_operand_sequencer_if
// Description : Operand bus, adder drive/return and result signals of the
//               operand sequencer. Optional chain input under ACCUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_operand_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             sub;
`ifdef ACCUM_EN
    logic             chain;
`endif
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             valid;
    logic             busy;

    modport master (
        output load, data_in, sub,
`ifdef ACCUM_EN
        output chain,
`endif
        output s_in,
        input  op_a, op_b, op_c, result, overflow, valid, busy
    );

    modport slave (
        input  load, data_in, sub,
`ifdef ACCUM_EN
        input  chain,
`endif
        input  s_in,
        output op_a, op_b, op_c, result, overflow, valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/addsub_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : addsub_operand_sequencer
// Description : Serially captures A and B from a shared bus, drives the
//               ripple adder, registers its sum and signed overflow.
//               Optional accumulate chaining enabled by macro ACCUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    addsub_operand_sequencer_if.slave  bus
);
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait_b = 2'd1;
    localparam logic [1:0] c_st_exec   = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;
    localparam int         c_msb       = WIDTH - 1;

    logic [1:0]       r_state,    w_state_nxt;
    logic             r_load_q;
    logic [WIDTH-1:0] r_op_a,     w_op_a_nxt;
    logic [WIDTH-1:0] r_op_b,     w_op_b_nxt;
    logic             r_op_c,     w_op_c_nxt;
    logic [WIDTH-1:0] r_result,   w_result_nxt;
    logic             r_overflow, w_overflow_nxt;
    logic             r_valid,    w_valid_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             w_load_edge;
    logic             w_bx_msb;
    logic             w_ovf;
    logic             w_chain;

`ifdef ACCUM_EN
    assign w_chain = bus.chain;
`else
    assign w_chain = 1'b0;
`endif

    assign w_load_edge = bus.load & ~r_load_q;
    // Overflow judged against the effective (possibly inverted) B operand
    assign w_bx_msb    = r_op_b[c_msb] ^ r_op_c;
    assign w_ovf       = (r_op_a[c_msb] == w_bx_msb) & (bus.s_in[c_msb] != r_op_a[c_msb]);

    always_comb begin
        w_state_nxt    = r_state;
        w_op_a_nxt     = r_op_a;
        w_op_b_nxt     = r_op_b;
        w_op_c_nxt     = r_op_c;
        w_result_nxt   = r_result;
        w_overflow_nxt = r_overflow;
        w_valid_nxt    = r_valid;
        case (r_state)
            c_st_idle: begin
                if (w_load_edge) begin
                    w_valid_nxt = 1'b0;
                    if (r_valid && w_chain) begin
                        // Accumulate: previous result becomes A, bus value is B
                        w_op_a_nxt  = r_result;
                        w_op_b_nxt  = bus.data_in;
                        w_op_c_nxt  = bus.sub;
                        w_state_nxt = c_st_exec;
                    end else begin
                        w_op_a_nxt  = bus.data_in;
                        w_state_nxt = c_st_wait_b;
                    end
                end
            end
            c_st_wait_b: begin
                if (w_load_edge) begin
                    w_op_b_nxt  = bus.data_in;
                    w_op_c_nxt  = bus.sub;
                    w_state_nxt = c_st_exec;
                end
            end
            c_st_exec: begin
                w_state_nxt = c_st_done;
            end
            c_st_done: begin
                w_result_nxt   = bus.s_in;
                w_overflow_nxt = w_ovf;
                w_valid_nxt    = 1'b1;
                w_state_nxt    = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        w_busy_nxt = (w_state_nxt == c_st_wait_b) | (w_state_nxt == c_st_exec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_load_q   <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_c     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_load_q   <= bus.load;
            r_op_a     <= w_op_a_nxt;
            r_op_b     <= w_op_b_nxt;
            r_op_c     <= w_op_c_nxt;
            r_result   <= w_result_nxt;
            r_overflow <= w_overflow_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.op_a     = r_op_a;
    assign bus.op_b     = r_op_b;
    assign bus.op_c     = r_op_c;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_addsub_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_operand_sequencer
// Description : Scoreboard bench for the operand sequencer with a behavioural
//               4-bit adder/subtractor on the return path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_operand_sequencer;
    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [WIDTH:0] exp_q[$];
    logic           prev_valid;

    addsub_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

    addsub_operand_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream adder: A + (B ^ C) + C
    assign bus.s_in = 4'(bus.op_a + (bus.op_b ^ {WIDTH{bus.op_c}}) + {3'b000, bus.op_c});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising valid delivers one result to compare
    always @(negedge clk) begin
        if (!reset && bus.valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("result", int'(bus.result), int'(e[WIDTH:1]));
                check("overflow", int'(bus.overflow), int'(e[0]));
            end
        end
        prev_valid <= bus.valid;
    end

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic [3:0] exp_r, input logic exp_o);
        exp_q.push_back({exp_r, exp_o});
        @(negedge clk); bus.load = 1'b1; bus.data_in = a;
        @(negedge clk); bus.load = 1'b0;
        @(negedge clk); bus.load = 1'b1; bus.data_in = b; bus.sub = s;
        @(posedge clk); #1;
        check("op_a", int'(bus.op_a), int'(a));
        check("op_c", int'(bus.op_c), int'(s));
        check("busy_exec", int'(bus.busy), 1);
        @(negedge clk); bus.load = 1'b0; bus.sub = 1'b0;
        @(posedge clk); #1;
        check("valid_early", int'(bus.valid), 0);
        @(posedge clk); #1;
        check("valid_latency", int'(bus.valid), 1);
        check("busy_done", int'(bus.busy), 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        prev_valid = 1'b0;
        reset      = 1'b1;
        bus.load    = 1'b0;
        bus.data_in = '0;
        bus.sub     = 1'b0;
`ifdef ACCUM_EN
        bus.chain   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_op_a", int'(bus.op_a), 0);
        check("rst_op_b", int'(bus.op_b), 0);
        check("rst_op_c", int'(bus.op_c), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy", int'(bus.busy), 0);

        do_op(4'd0, 4'd0, 1'b1, 4'b0000, 1'b0);
        do_op(4'd3, 4'd2, 1'b0, 4'b0101, 1'b0);
        do_op(4'd3, 4'd5, 1'b1, 4'b1110, 1'b0);
        do_op(4'd7, 4'd1, 1'b0, 4'b1000, 1'b1);
        do_op(4'd8, 4'd1, 1'b1, 4'b0111, 1'b1);

        // Held load counts once: only A captured
        @(negedge clk); bus.load = 1'b1; bus.data_in = 4'd6;
        repeat (5) @(posedge clk);
        #1;
        check("held_op_a", int'(bus.op_a), 6);
        check("held_op_b", int'(bus.op_b), 1);
        check("held_busy", int'(bus.busy), 1);
        check("held_valid", int'(bus.valid), 0);
        @(negedge clk); bus.load = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop_rst_op_a", int'(bus.op_a), 0);
        check("midop_rst_valid", int'(bus.valid), 0);
        check("midop_rst_busy", int'(bus.busy), 0);

        do_op(4'd8, 4'd8, 1'b0, 4'b0000, 1'b1);
        do_op(4'd4, 4'd6, 1'b1, 4'b1110, 1'b0);

`ifdef ACCUM_EN
        do_op(4'd2, 4'd3, 1'b0, 4'b0101, 1'b0);
        exp_q.push_back({4'b1001, 1'b1});
        @(negedge clk); bus.chain = 1'b1; bus.load = 1'b1; bus.data_in = 4'd4; bus.sub = 1'b0;
        @(posedge clk); #1;
        check("chain_op_a", int'(bus.op_a), 5);
        check("chain_op_b", int'(bus.op_b), 4);
        check("chain_busy", int'(bus.busy), 1);
        @(negedge clk); bus.load = 1'b0; bus.chain = 1'b0;
        @(posedge clk); #1;
        check("chain_valid_early", int'(bus.valid), 0);
        @(posedge clk); #1;
        check("chain_valid_latency", int'(bus.valid), 1);
`endif

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
